// File: rtl/instr_word_encoder.sv
// Packs instruction field bundles into 32-bit MIPS words and streams them to instruction memory.
// Optional INSTR_CHECKSUM_EN adds a running XOR of every word written this session.
module instr_word_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal
`ifdef INSTR_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // LOAD  | in_ready high, waiting for a field bundle
  // WRITE | mem_we high for the captured word
  // DONE  | session finished, waiting for start
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_t              r_state;
  logic                r_in_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_done;
  logic [ADDR_W:0]     r_count;
  logic                r_err;
  logic                r_last;
  logic [31:0]         r_checksum;
  logic [31:0]         w_word;
  logic                w_legal;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (in_kind)
      4'd0:    w_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
      4'd1:    w_word = {6'h23, in_rs, in_rt, in_imm};
      4'd2:    w_word = {6'h2B, in_rs, in_rt, in_imm};
      4'd3:    w_word = {6'h04, in_rs, in_rt, in_imm};
      4'd4:    w_word = {6'h0D, in_rs, in_rt, in_imm};
      4'd5:    w_word = {6'h11, in_rs, in_rt, in_imm};
      4'd6:    w_word = {6'h19, in_target};
      4'd7:    w_word = {6'h21, in_rs, in_rt, in_imm};
      4'd8:    w_word = {6'h02, in_target};
      4'd9:    w_word = {6'h0B, in_rs, in_rt, in_imm};
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= BASE;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_last     <= 1'b0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_addr     <= BASE;
            r_checksum <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (w_legal) begin
              r_state    <= S_WRITE;
              r_in_ready <= 1'b0;
              r_we       <= 1'b1;
              r_wdata    <= w_word;
              r_last     <= in_last;
            end else begin
              // illegal bundles are consumed without a write but still honour in_last
              r_err <= 1'b1;
              if (in_last) begin
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          r_we       <= 1'b0;
          r_addr     <= r_addr + 1'b1;
          r_checksum <= r_checksum ^ r_wdata;
          if (r_count <= LAST_CNT) r_count <= r_count + 1'b1;
          if (r_last || r_count == LAST_CNT) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_we       <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign done        = r_done;
  assign count       = r_count;
  assign err_illegal = r_err;
`ifdef INSTR_CHECKSUM_EN
  assign checksum    = r_checksum;
`endif

endmodule

// File: tb/tb_instr_word_encoder.sv
// Scoreboard bench for instr_word_encoder: directed spec vectors plus random sessions
// checked against a field-packing reference model; small memory (ADDR_W=3, BASE=5) to hit wrap and capacity.
module tb_instr_word_encoder;
  localparam int AW   = 3;
  localparam int BASE = 5;
  localparam int CAP  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          done;
  logic [AW:0]   count;
  logic          err_illegal;
`ifdef INSTR_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  instr_word_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
    .count(count), .err_illegal(err_illegal)
`ifdef INSTR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          m_n;
  bit          m_err;
  logic [31:0] m_cs;

  int unsigned OPC [10] = '{32'h00, 32'h23, 32'h2B, 32'h04, 32'h0D,
                            32'h11, 32'h19, 32'h21, 32'h02, 32'h0B};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: opcode table + format class, assembled with shifts by field position.
  function automatic logic [31:0] ref_word(input int k, input logic [4:0] rs, rt, rd, sh,
                                           input logic [5:0] fn, input logic [15:0] imm,
                                           input logic [25:0] tgt);
    logic [31:0] w;
    w = 32'(OPC[k]) << 26;
    if (k == 0)
      w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    else if (k == 6 || k == 8)
      w = w | 32'(tgt);
    else
      w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0h data %0h expected=no write", mem_addr, mem_wdata);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("wr_data", mem_wdata, mon_e.data);
        m_cs = m_cs ^ mon_e.data;
      end
    end
  end

  task automatic send(input int k, input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input bit last,
                      input bit use_lit, input logic [31:0] lit, output bit acc);
    bit   gave_up;
    exp_t e;
    in_kind = 4'(k); in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
    in_valid = 1'b1;
    acc = 1'b0;
    gave_up = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        acc = 1'b1;
        if (k < 10) begin
          e.addr = AW'((BASE + m_n) % CAP);
          e.data = use_lit ? lit : ref_word(k, rs, rt, rd, sh, fn, imm, tgt);
          q.push_back(e);
          m_n++;
        end else begin
          m_err = 1'b1;
        end
        break;
      end
      if (done === 1'b1) begin
        gave_up = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc && !gave_up) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not accepted expected=accepted");
    end
    if (acc) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_n = 0;
    m_err = 1'b0;
    m_cs = '0;
    chk("start_count", 32'(count), 32'd0);
    chk("start_err", 32'(err_illegal), 32'd0);
    chk("start_done", 32'(done), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic finish_check(input string tag);
    for (int t = 0; t < 30; t++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_count"}, 32'(count), 32'(m_n));
    chk({tag, "_err"}, 32'(err_illegal), 32'(m_err));
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
`ifdef INSTR_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, m_cs);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          nb, k;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
    m_n = 0; m_err = 1'b0; m_cs = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
`ifdef INSTR_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'd0);
`endif

    do_start();
    send(1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1, 1'b1, 32'h8C220004, acc);
    finish_check("lw");

    // start pulsed mid-session must not restart the session
    do_start();
    send(0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 1'b1, 32'h00642820, acc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1'b1, 1'b1, 32'h08000010, acc);
    finish_check("rj");

    do_start();
    send(12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0, 1'b0, 32'd0, acc);
    send(4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1, 1'b1, 32'h3408FFFF, acc);
    finish_check("illegal");

    do_start();
    send(1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 1'b1, 32'h8C220004, acc);
    send(4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1, 1'b1, 32'h3408FFFF, acc);
    finish_check("pair");
`ifdef INSTR_CHECKSUM_EN
    chk("checksum_pair", checksum, 32'hB82AFFFB);
    do_start();
    chk("checksum_cleared", checksum, 32'd0);
    send(3, 5'd7, 5'd9, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1, 1'b0, 32'd0, acc);
    finish_check("cs_beq");
`endif

    // capacity: stream more bundles than memory holds, never asserting last
    do_start();
    for (int i = 0; i < CAP + 3; i++) begin
      send($urandom_range(9, 0), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           6'($urandom), 16'($urandom), 26'($urandom), 1'b0, 1'b0, 32'd0, acc);
      if (!acc) break;
    end
    finish_check("capacity");
    chk("capacity_full", 32'(m_n), 32'(CAP));

    // asynchronous reset during the write cycle
    do_start();
    in_kind = 4'd1; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h0004; in_last = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    in_valid = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_idle_ready", 32'(in_ready), 32'd0);
    chk("abort_idle_done", 32'(done), 32'd0);
    chk("abort_idle_addr", 32'(mem_addr), 32'(BASE));

    for (int s = 0; s < 25; s++) begin
      do_start();
      nb = $urandom_range(6, 1);
      for (int i = 0; i < nb; i++) begin
        k = ($urandom_range(7, 0) == 0) ? $urandom_range(15, 10) : $urandom_range(9, 0);
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        fn = 6'($urandom); imm = 16'($urandom); tgt = 26'($urandom);
        send(k, rs, rt, rd, sh, fn, imm, tgt, i == nb - 1, 1'b0, 32'd0, acc);
        if (!acc) break;
      end
      finish_check("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
